// File: rtl/i2c_pkg.sv
// i2c_pkg: shared constants, FSM encoding and id sizing helper for the I2C bus arbiter
package i2c_pkg;
  localparam int I2C_CMD_W = 24;
  localparam logic ACK_OK = 1'b0;
  typedef enum logic [2:0] {IDLE, START, XFER, EVAL, GAP} state_t;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/i2c_bus_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, lowest index at or after ptr wins
// ports: req (request vector), ptr (first index to consider), gnt (one-hot winner), id (binary winner)
module rr_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ = 3,
  localparam int IW = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      id
);
  always_comb begin
    gnt = '0;
    id = '0;
    // scan from the farthest offset down so the nearest requester is the last writer
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        id = IW'((int'(ptr) + k) % NUM_REQ);
        gnt = NUM_REQ'(1) << ((int'(ptr) + k) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin sharing of one i2c_controller among NUM_REQ register-write requesters
// ports: iCLK/iRST_N clock and async active-low reset; iREQ/iREQ_DATA per-requester request and
// {slave,sub,data} command; oACCEPT/oDONE/oERR per-requester one-cycle pulses; oI2C_DATA/oI2C_GO
// command and start to the controller; iI2C_END/iI2C_ACK controller flags (async); oBUSY not idle
module i2c_bus_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT_CYC = 500000,
  parameter int GAP_CYC = 5000
) (
  input  logic                           iCLK,
  input  logic                           iRST_N,
  input  logic [NUM_REQ-1:0]             iREQ,
  input  logic [I2C_CMD_W*NUM_REQ-1:0]   iREQ_DATA,
  output logic [NUM_REQ-1:0]             oACCEPT,
  output logic [NUM_REQ-1:0]             oDONE,
  output logic [NUM_REQ-1:0]             oERR,
  output logic [I2C_CMD_W-1:0]           oI2C_DATA,
  output logic                           oI2C_GO,
  input  logic                           iI2C_END,
  input  logic                           iI2C_ACK,
  output logic                           oBUSY
);
  localparam int IW = id_w(NUM_REQ);
  localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYC - 1);
  localparam logic [19:0] GAP_LAST = 20'(GAP_CYC - 1);
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, id_q, id_d, win_id;
  logic [NUM_REQ-1:0] win_gnt, sel, acc_q, acc_d, done_q, done_d, err_q, err_d;
  logic [3:0] retry_q, retry_d;
  logic again_q, again_d;
  logic [19:0] timer_q, timer_d, gap_q, gap_d;
  logic [I2C_CMD_W-1:0] data_q, data_d;
  logic [1:0] end_sync_q, ack_sync_q;
  logic end_s, ack_s, timed_out;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req(iREQ),
    .ptr(ptr_q),
    .gnt(win_gnt),
    .id (win_id)
  );
  assign end_s = end_sync_q[1];
  assign ack_s = ack_sync_q[1];
  assign sel = NUM_REQ'(1) << id_q;
  assign timed_out = (state_q == START || state_q == XFER) && timer_q == TO_LAST;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    retry_d = retry_q;
    again_d = again_q;
    timer_d = '0;
    gap_d = '0;
    data_d = data_q;
    acc_d = '0;
    done_d = '0;
    err_d = '0;
    case (state_q)
      IDLE: if (|iREQ) begin
        state_d = START;
        id_d = win_id;
        ptr_d = (int'(win_id) == NUM_REQ - 1) ? '0 : IW'(int'(win_id) + 1);
        data_d = iREQ_DATA[int'(win_id)*I2C_CMD_W +: I2C_CMD_W];
        acc_d = win_gnt;
        retry_d = '0;
        again_d = 1'b0;
      end
      START: begin
        timer_d = timer_q + 20'd1;
        state_d = end_s ? START : XFER;
      end
      XFER: begin
        timer_d = timer_q + 20'd1;
        state_d = end_s ? EVAL : XFER;
      end
      EVAL: begin
        state_d = GAP;
        again_d = 1'b0;
        if (ack_s == ACK_OK) done_d = sel;
        else if (retry_q < 4'(MAX_RETRY)) begin
          retry_d = retry_q + 4'd1;
          again_d = 1'b1;
        end
        else err_d = sel;
      end
      GAP: begin
        gap_d = gap_q + 20'd1;
        if (gap_q == GAP_LAST) state_d = again_q ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a hung controller is abandoned without retry
    if (timed_out) begin
      state_d = GAP;
      err_d = sel;
      again_d = 1'b0;
    end
  end
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      ptr_q <= '0;
      id_q <= '0;
      retry_q <= '0;
      again_q <= 1'b0;
      timer_q <= '0;
      gap_q <= '0;
      data_q <= '0;
      acc_q <= '0;
      done_q <= '0;
      err_q <= '0;
      end_sync_q <= '0;
      ack_sync_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      retry_q <= retry_d;
      again_q <= again_d;
      timer_q <= timer_d;
      gap_q <= gap_d;
      data_q <= data_d;
      acc_q <= acc_d;
      done_q <= done_d;
      err_q <= err_d;
      end_sync_q <= {end_sync_q[0], iI2C_END};
      ack_sync_q <= {ack_sync_q[0], iI2C_ACK};
    end
  end
  assign oACCEPT = acc_q;
  assign oDONE = done_q;
  assign oERR = err_q;
  assign oI2C_DATA = data_q;
  assign oI2C_GO = state_q == START || state_q == XFER;
  assign oBUSY = state_q != IDLE;
endmodule
